// File: rtl/cpc_pkg.sv
// Shared definitions for the count pulse conditioner: FSM state encoding,
// parameter defaults and the counter width helper.
package cpc_pkg;

  // Gray-adjacent encoding: every legal transition flips a single bit
  localparam logic [1:0] IDLE         = 2'b00;
  localparam logic [1:0] PRESS_WAIT   = 2'b01;
  localparam logic [1:0] PRESSED      = 2'b11;
  localparam logic [1:0] RELEASE_WAIT = 2'b10;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int REPEAT_EN_DEF       = 0;
  localparam int REPEAT_CYCLES_DEF   = 8;

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/count_pulse_conditioner_if.sv
// Button-side signal bundle: raw level in, conditioned pulse and held level out.
interface count_pulse_conditioner_if;
  logic raw_in;
  logic pulse_out;
  logic held;

  modport master (output raw_in, input pulse_out, input held);
  modport slave  (input raw_in, output pulse_out, output held);
endinterface

// File: rtl/count_pulse_conditioner_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, cleared by synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;

  // metastability filter chain
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/count_pulse_conditioner.sv
// Turns a bouncy asynchronous button level into single-cycle count-enable
// pulses, with optional auto-repeat while the press is held.
module count_pulse_conditioner
  import cpc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_EN       = REPEAT_EN_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input logic                       clk,
  input logic                       reset,
  count_pulse_conditioner_if.slave  bus
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync2_s;
  logic [1:0]       state_r;
  logic [1:0]       next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] next_cnt_s;
  logic             next_pulse_s;
  logic             next_held_s;
  logic             pulse_r;
  logic             held_r;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.raw_in),
    .q     (sync2_s)
  );

  // debounce / auto-repeat next-state logic
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    next_pulse_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sync2_s) begin
          next_state_s = PRESS_WAIT;
          next_cnt_s   = '0;
        end else begin
          next_cnt_s   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_s) begin
          next_state_s = IDLE;
          next_cnt_s   = '0;
        end else if (cnt_r == DB_LAST) begin
          next_state_s = PRESSED;
          next_pulse_s = 1'b1;
          next_cnt_s   = '0;
        end else begin
          next_cnt_s   = cnt_r + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync2_s) begin
          next_state_s = RELEASE_WAIT;
          next_cnt_s   = '0;
        end else if (cnt_r == RP_LAST) begin
          // without repeat the count parks here instead of wrapping
          if (REPEAT_EN != 0) begin
            next_pulse_s = 1'b1;
            next_cnt_s   = '0;
          end else begin
            next_cnt_s   = cnt_r;
          end
        end else begin
          next_cnt_s   = cnt_r + CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_s) begin
          next_state_s = PRESSED;
          next_cnt_s   = '0;
        end else if (cnt_r == DB_LAST) begin
          next_state_s = IDLE;
          next_cnt_s   = '0;
        end else begin
          next_cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_cnt_s   = '0;
      end
    endcase
    next_held_s = (next_state_s == PRESSED) || (next_state_s == RELEASE_WAIT);
  end

  // state, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      pulse_r <= 1'b0;
      held_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      pulse_r <= next_pulse_s;
      held_r  <= next_held_s;
    end
  end

  assign bus.pulse_out = pulse_r;
  assign bus.held      = held_r;

endmodule

// File: tb/tb_count_pulse_conditioner.sv
// Randomized + directed bench: two conditioners (repeat off / on) share one
// raw input; a run-length reference model feeds a per-cycle scoreboard.
module tb_count_pulse_conditioner;

  localparam int D = 4;
  localparam int R = 8;

  typedef struct packed {
    bit p0;
    bit h0;
    bit p1;
    bit h1;
  } exp_t;

  logic clk;
  logic reset;
  logic raw;

  int checks   = 0;
  int failures = 0;
  int pc0      = 0;
  int pc1      = 0;

  exp_t exp_q[$];

  count_pulse_conditioner_if bus0 ();
  count_pulse_conditioner_if bus1 ();

  assign bus0.raw_in = raw;
  assign bus1.raw_in = raw;

  count_pulse_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_CYCLES(R)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  count_pulse_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_CYCLES(R)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: press accepted after D+1 consecutive high samples of the
  // 2-cycle-delayed input, released after D+1 consecutive lows; repeat pulses
  // every R cycles counted from the press or from the last re-press.
  initial begin : model
    bit d1, d2, s;
    bit pressed [2];
    int hi_run [2];
    int lo_run [2];
    int age [2];
    bit pul [2];
    exp_t e;
    d1 = 1'b0;
    d2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pressed[i] = 1'b0; hi_run[i] = 0; lo_run[i] = 0; age[i] = 0;
    end
    forever begin
      @(posedge clk);
      if (reset) begin
        d1 = 1'b0;
        d2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
          pressed[i] = 1'b0; hi_run[i] = 0; lo_run[i] = 0; age[i] = 0; pul[i] = 1'b0;
        end
      end else begin
        s  = d2;
        d2 = d1;
        d1 = raw;
        for (int i = 0; i < 2; i++) begin
          pul[i] = 1'b0;
          if (!pressed[i]) begin
            hi_run[i] = s ? hi_run[i] + 1 : 0;
            if (hi_run[i] == D + 1) begin
              pressed[i] = 1'b1; pul[i] = 1'b1; age[i] = 0; lo_run[i] = 0;
            end
          end else if (s) begin
            if (lo_run[i] > 0) begin
              age[i] = 0; lo_run[i] = 0;
            end else begin
              age[i]++;
              if (i == 1 && age[i] == R) begin
                pul[i] = 1'b1; age[i] = 0;
              end
            end
          end else begin
            lo_run[i]++;
            if (lo_run[i] == D + 1) begin
              pressed[i] = 1'b0; hi_run[i] = 0;
            end
          end
        end
      end
      e.p0 = pul[0];
      e.h0 = pressed[0];
      e.p1 = pul[1];
      e.h1 = pressed[1];
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs against the oldest expectation each cycle
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (bus0.pulse_out === 1'b1) pc0++;
      if (bus1.pulse_out === 1'b1) pc1++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=0 expected>=1 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_dut0", int'(bus0.pulse_out), int'(e.p0));
        chk("held_dut0",  int'(bus0.held),      int'(e.h0));
        chk("pulse_dut1", int'(bus1.pulse_out), int'(e.p1));
        chk("held_dut1",  int'(bus1.held),      int'(e.h1));
      end
    end
  end

  task automatic hold(input bit v, input int n);
    for (int k = 0; k < n; k++) begin
      raw = v;
      @(negedge clk);
    end
  endtask

  initial begin : stim
    int c0, c1;
    bit lvl;
    reset = 1'b1;
    raw   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pulse", int'(bus0.pulse_out), 0);
    chk("reset_held",  int'(bus0.held), 0);
    reset = 1'b0;
    hold(1'b0, 4);

    // clean press
    c0 = pc0; c1 = pc1;
    hold(1'b1, 20);
    hold(1'b0, 20);
    chk("clean_press_cnt0", pc0 - c0, 1);
    chk("clean_press_cnt1", pc1 - c1, 2);

    // bounce rejection
    c0 = pc0; c1 = pc1;
    hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 20);
    chk("bounce_cnt0", pc0 - c0, 0);
    chk("bounce_cnt1", pc1 - c1, 0);

    // release bounce
    c0 = pc0; c1 = pc1;
    hold(1'b1, 12); hold(1'b0, 2); hold(1'b1, 3); hold(1'b0, 20);
    chk("release_bounce_cnt0", pc0 - c0, 1);
    chk("release_bounce_cnt1", pc1 - c1, 1);

    // auto-repeat
    c0 = pc0; c1 = pc1;
    hold(1'b1, 40);
    hold(1'b0, 20);
    chk("repeat_cnt0", pc0 - c0, 1);
    chk("repeat_cnt1", pc1 - c1, 5);

    // reset mid-press
    c0 = pc0;
    hold(1'b1, 4);
    reset = 1'b1;
    hold(1'b1, 2);
    chk("midreset_pulse", int'(bus0.pulse_out), 0);
    chk("midreset_held",  int'(bus0.held), 0);
    reset = 1'b0;
    hold(1'b1, 6);
    chk("midreset_no_early_pulse", pc0 - c0, 0);
    hold(1'b1, 14);
    hold(1'b0, 20);
    chk("midreset_cnt0", pc0 - c0, 1);

    // eight presses
    c0 = pc0;
    for (int k = 0; k < 8; k++) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    chk("eight_press_cnt0", pc0 - c0, 8);

    // random bouncing levels, checked cycle by cycle
    lvl = 1'b0;
    for (int k = 0; k < 400; k++) begin
      lvl = ~lvl;
      hold(lvl, int'($urandom_range(1, 14)));
      if ($urandom_range(0, 60) == 0) begin
        reset = 1'b1;
        hold(lvl, 1);
        reset = 1'b0;
      end
    end
    hold(1'b0, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
